// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared port ids, FSM state and read-tag types for the RAM arbiter
package mem_arbiter_pkg;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} arb_state_t;
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port (req/we/addr/wdata in, gnt/stall/rvalid/rdata out)
interface mem_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic gnt;
  logic stall;
  logic rvalid;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, wdata, input gnt, stall, rvalid, rdata);
  modport slave (input req, we, addr, wdata, output gnt, stall, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// mem_arbiter_rd_tag_pipe: DEPTH-stage shift register of {valid,id} tracking reads in flight
// Ports: clk, rst_n (async clear), tag_in (issued this cycle), tag_out (tag whose data is on the RAM bus now)
module mem_arbiter_rd_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);
  rd_tag_t stage [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end
  assign tag_out = stage[DEPTH-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between the CPU port (priority) and a starvation-bounded, lockable debug port
// Ports: clk, rst_n (async, active low); cpu/dbg requester ports; dbg_lock (hold RAM after next dbg grant);
//        mem_wr_sig/mem_wr_data/mem_addr to the RAM, mem_rd_data from it RD_LATENCY cycles after the address
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      cpu,
  mem_arbiter_if.slave      dbg,
  input  logic              dbg_lock,
  output logic              mem_wr_sig,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  arb_state_t state, state_nx;
  logic [CNT_W-1:0] starve_cnt;
  logic starved, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
  rd_tag_t tag_in, tag_out;
  assign starved = starve_cnt == CNT_W'(STARVE_MAX);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ARB;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == ST_ARB ? ((dbg_gnt && dbg_lock) ? ST_LOCK : ST_ARB)
                               : (dbg_lock ? ST_LOCK : ST_ARB);
  end
  // Grants are gated by rst_n so every output reads zero while reset is held.
  always_comb begin
    dbg_gnt = rst_n && dbg.req && (state == ST_LOCK || !cpu.req || starved);
    cpu_gnt = rst_n && cpu.req && state == ST_ARB && !dbg_gnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else if (!dbg.req || dbg_gnt) starve_cnt <= '0;
    else if (!starved) starve_cnt <= starve_cnt + 1'b1;
  end
  always_comb begin
    mem_wr_sig  = (cpu_gnt && cpu.we) || (dbg_gnt && dbg.we);
    mem_addr    = dbg_gnt ? dbg.addr : cpu_gnt ? cpu.addr : '0;
    mem_wr_data = dbg_gnt ? dbg.wdata : cpu_gnt ? cpu.wdata : '0;
    tag_in.valid = (cpu_gnt && !cpu.we) || (dbg_gnt && !dbg.we);
    tag_in.id    = dbg_gnt ? PORT_DBG : PORT_CPU;
  end
  mem_arbiter_rd_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );
  assign cpu_rvalid = tag_out.valid && tag_out.id == PORT_CPU;
  assign dbg_rvalid = tag_out.valid && tag_out.id == PORT_DBG;
  assign cpu.gnt    = cpu_gnt;
  assign dbg.gnt    = dbg_gnt;
  assign cpu.stall  = rst_n && cpu.req && !cpu_gnt;
  assign dbg.stall  = rst_n && dbg.req && !dbg_gnt;
  assign cpu.rvalid = cpu_rvalid;
  assign dbg.rvalid = dbg_rvalid;
  assign cpu.rdata  = cpu_rvalid ? mem_rd_data : '0;
  assign dbg.rdata  = dbg_rvalid ? mem_rd_data : '0;
endmodule
